// File: rtl/ps2_mouse_decoder_pkg.sv
// Shared constants, receiver state encoding and the movement-magnitude helper
// for the PS/2 mouse decoder.
package ps2_mouse_decoder_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PACKET_BYTES   = 3;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // |{sign, mv}| as 0..256; an overflowed axis reports the largest 8-bit speed.
    function automatic logic [8:0] move_mag(input logic sign, input logic [7:0] mv,
                                            input logic ovf);
        logic [8:0] v;
        v = {sign, mv};
        if (ovf)
            return 9'd255;
        else if (sign)
            return ~v + 9'd1;
        else
            return v;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: synchronizers, glitch filter, falling-edge strobe and the
// 11-bit frame FSM with odd-parity/stop checking and an idle timeout.
module ps2_frame_rx
    import ps2_mouse_decoder_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pkt_busy,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       timeout
);

    localparam int DATA_BITS = PS2_FRAME_BITS - 3;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt, filt_d;
    logic [FW-1:0] filt_cnt;
    logic          strobe;
    logic          frame_ok;
    logic          active;

    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            filt_d <= filt;
            // Any sample agreeing with the current level restarts the run count.
            if (clk_s2 == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt     <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign strobe     = filt_d & ~filt;
    assign frame_ok   = dat_s2 & (^{shreg, par});
    assign active     = (state != RX_IDLE) || pkt_busy;
    assign timeout    = !strobe && active && (to_cnt == TO_LAST);
    assign byte_valid = strobe && (state == RX_STOP) && frame_ok;
    assign byte_err   = strobe && (state == RX_STOP) && !frame_ok;
    assign rx_byte    = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (strobe || timeout || !active)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TW'(1);

            if (timeout) begin
                state <= RX_IDLE;
            end else if (strobe) begin
                case (state)
                    RX_IDLE: begin
                        if (!dat_s2) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg <= {dat_s2, shreg[7:1]};
                        if (bit_cnt == DATA_LAST)
                            state <= RX_PARITY;
                        else
                            bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: begin
                        par   <= dat_s2;
                        state <= RX_STOP;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse front end: assembles 3-byte stream packets and turns each one into
// speed magnitude, direction and button state for the object mover.
module ps2_mouse_decoder
    import ps2_mouse_decoder_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int GAIN_SHIFT     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] vx,
    output logic [8:0] vy,
    output logic       dx,
    output logic       dy,
    output logic       mousepush,
    output logic       mouse_right,
    output logic       mouseReady,
    output logic       frame_err
);

    localparam int SW = 10 + GAIN_SHIFT;
    localparam logic [1:0] LAST_IDX = 2'(PACKET_BYTES - 1);

    logic [7:0]    rx_byte;
    logic          byte_valid, byte_err, timeout;
    logic [1:0]    idx;
    logic          b0_l, b0_r, b0_xs, b0_ys, b0_xo, b0_yo;
    logic [7:0]    b1;
    logic [8:0]    x_mag, y_mag;
    logic [SW-1:0] x_wide, y_wide;
    logic [9:0]    vx_next;
    logic [8:0]    vy_next;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .pkt_busy  (idx != 2'd0),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .byte_err  (byte_err),
        .timeout   (timeout)
    );

    // Byte 2 is consumed straight off the receiver on its good stop strobe.
    always_comb begin
        x_mag   = move_mag(b0_xs, b1, b0_xo);
        y_mag   = move_mag(b0_ys, rx_byte, b0_yo);
        x_wide  = SW'(x_mag) << GAIN_SHIFT;
        y_wide  = SW'(y_mag) << GAIN_SHIFT;
        vx_next = (x_wide > SW'(10'h3FF)) ? 10'h3FF : x_wide[9:0];
        vy_next = (y_wide > SW'(9'h1FF)) ? 9'h1FF : y_wide[8:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            b0_l        <= 1'b0;
            b0_r        <= 1'b0;
            b0_xs       <= 1'b0;
            b0_ys       <= 1'b0;
            b0_xo       <= 1'b0;
            b0_yo       <= 1'b0;
            b1          <= '0;
            vx          <= '0;
            vy          <= '0;
            dx          <= 1'b0;
            dy          <= 1'b0;
            mousepush   <= 1'b0;
            mouse_right <= 1'b0;
            mouseReady  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            mouseReady <= 1'b0;
            frame_err  <= 1'b0;
            if (timeout || byte_err) begin
                idx       <= '0;
                frame_err <= 1'b1;
            end else if (byte_valid) begin
                if (idx == 2'd0) begin
                    // A clear sync bit means we are mid-packet; stay at byte 0.
                    if (rx_byte[SYNC]) begin
                        b0_l  <= rx_byte[BTN_L];
                        b0_r  <= rx_byte[BTN_R];
                        b0_xs <= rx_byte[XSIGN];
                        b0_ys <= rx_byte[YSIGN];
                        b0_xo <= rx_byte[XOVF];
                        b0_yo <= rx_byte[YOVF];
                        idx   <= 2'd1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else if (idx == 2'd1) begin
                    b1  <= rx_byte;
                    idx <= LAST_IDX;
                end else begin
                    vx          <= vx_next;
                    vy          <= vy_next;
                    dx          <= !b0_xs && (b1 != 8'd0);
                    dy          <= b0_ys;
                    mousepush   <= b0_l;
                    mouse_right <= b0_r;
                    mouseReady  <= 1'b1;
                    idx         <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Directed bench for ps2_mouse_decoder: a unity-gain and a gain-4 instance share
// one PS/2 line; a packet table plus hand sequences for error and reset cases.
module tb_ps2_mouse_decoder;

    localparam int TO = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;

    logic [9:0] vx0, vx2;
    logic [8:0] vy0, vy2;
    logic       dx0, dy0, push0, right0, ready0, ferr0;
    logic       dx2, dy2, push2, right2, ready2, ferr2;

    ps2_mouse_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .GAIN_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .vx(vx0), .vy(vy0), .dx(dx0), .dy(dy0), .mousepush(push0),
        .mouse_right(right0), .mouseReady(ready0), .frame_err(ferr0)
    );

    ps2_mouse_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .GAIN_SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .vx(vx2), .vy(vy2), .dx(dx2), .dy(dy2), .mousepush(push2),
        .mouse_right(right2), .mouseReady(ready2), .frame_err(ferr2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [9:0] vx;
        logic [8:0] vy;
        logic       dx, dy, push, right;
        logic [9:0] vx2;
        logic [8:0] vy2;
    } vec_t;

    vec_t vecs[7];
    vec_t gvec;

    int errors = 0;
    int checks = 0;
    int ready_cnt = 0, ready2_cnt = 0, ferr_cnt = 0, ferr2_cnt = 0;

    // Pulse counters count high cycles, so a stretched pulse shows up as >1.
    always @(negedge clk) begin
        if (ready0) ready_cnt++;
        if (ready2) ready2_cnt++;
        if (ferr0)  ferr_cnt++;
        if (ferr2)  ferr2_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        @(posedge clk);
        ps2_data = b;
        wait_clk(10);
        if (glitch) begin
            ps2_clk = 1'b0; wait_clk(1); ps2_clk = 1'b1; wait_clk(1);
        end
        ps2_clk = 1'b0;
        wait_clk(10);
        if (glitch) begin
            ps2_clk = 1'b1; wait_clk(1); ps2_clk = 1'b0;
        end
        wait_clk(10);
        ps2_clk = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic par;
        par = ~(^b);
        if (bad_par) par = ~par;
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(par, glitch);
        send_bit(1'b1, glitch);
        ps2_data = 1'b1;
        wait_clk(60);
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit glitch);
        int r0, r2, f0, f2;
        r0 = ready_cnt; r2 = ready2_cnt; f0 = ferr_cnt; f2 = ferr2_cnt;
        send_byte(v.b0, 1'b0, glitch);
        send_byte(v.b1, 1'b0, glitch);
        send_byte(v.b2, 1'b0, glitch);
        wait_clk(5);
        @(negedge clk);
        check({tag, "_ready"},   ready_cnt - r0, 1);
        check({tag, "_ready2"},  ready2_cnt - r2, 1);
        check({tag, "_ferr"},    ferr_cnt - f0, 0);
        check({tag, "_ferr2"},   ferr2_cnt - f2, 0);
        check({tag, "_vx"},      vx0, v.vx);
        check({tag, "_vy"},      vy0, v.vy);
        check({tag, "_dx"},      dx0, v.dx);
        check({tag, "_dy"},      dy0, v.dy);
        check({tag, "_push"},    push0, v.push);
        check({tag, "_right"},   right0, v.right);
        check({tag, "_vx_g2"},   vx2, v.vx2);
        check({tag, "_vy_g2"},   vy2, v.vy2);
        check({tag, "_dx_g2"},   dx2, v.dx);
        check({tag, "_dy_g2"},   dy2, v.dy);
        check({tag, "_push_g2"}, push2, v.push);
        check({tag, "_right_g2"}, right2, v.right);
    endtask

    initial begin
        int r0, f0;
        //          b0     b1     b2     vx       vy      dx    dy    push  right vx2       vy2
        vecs[0] = '{8'h09, 8'h05, 8'h00, 10'd5,   9'd0,   1'b1, 1'b0, 1'b1, 1'b0, 10'd20,   9'd0};
        vecs[1] = '{8'h38, 8'hFB, 8'hFD, 10'd5,   9'd3,   1'b0, 1'b1, 1'b0, 1'b0, 10'd20,   9'd12};
        vecs[2] = '{8'h48, 8'h10, 8'h00, 10'd255, 9'd0,   1'b1, 1'b0, 1'b0, 1'b0, 10'd1020, 9'd0};
        vecs[3] = '{8'h18, 8'h00, 8'h00, 10'd256, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 10'd1023, 9'd0};
        vecs[4] = '{8'h0A, 8'h01, 8'h01, 10'd1,   9'd1,   1'b1, 1'b0, 1'b0, 1'b1, 10'd4,    9'd4};
        vecs[5] = '{8'hA8, 8'h00, 8'h80, 10'd0,   9'd255, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,    9'd511};
        vecs[6] = '{8'h29, 8'h00, 8'h00, 10'd0,   9'd256, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0,    9'd511};
        gvec    = '{8'h0A, 8'h03, 8'h00, 10'd3,   9'd0,   1'b1, 1'b0, 1'b0, 1'b1, 10'd12,   9'd0};

        // Clock/reset
        wait_clk(5);
        @(negedge clk);
        check("rst_vx", vx0, 0);
        check("rst_vy", vy0, 0);
        check("rst_dx", dx0, 0);
        check("rst_dy", dy0, 0);
        check("rst_push", push0, 0);
        check("rst_right", right0, 0);
        check("rst_ready", ready0, 0);
        check("rst_ferr", ferr0, 0);
        rst_n = 1'b1;
        wait_clk(20);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Bad parity on byte 1, then a clean packet.
        r0 = ready_cnt; f0 = ferr_cnt;
        send_byte(8'h0A, 1'b0, 1'b0);
        send_byte(8'h01, 1'b1, 1'b0);
        wait_clk(5);
        check("parity_ferr", ferr_cnt - f0, 1);
        check("parity_noready", ready_cnt - r0, 0);
        run_vec("parity_recover", vecs[4], 1'b0);

        // Sync bit clear on byte 0.
        r0 = ready_cnt; f0 = ferr_cnt;
        send_byte(8'h00, 1'b0, 1'b0);
        wait_clk(5);
        check("sync_ferr", ferr_cnt - f0, 1);
        check("sync_noready", ready_cnt - r0, 0);
        run_vec("sync_recover", vecs[0], 1'b0);

        // Byte 0 then silence past the timeout.
        r0 = ready_cnt; f0 = ferr_cnt;
        send_byte(8'h09, 1'b0, 1'b0);
        wait_clk(TO + 10);
        check("timeout_ferr", ferr_cnt - f0, 1);
        check("timeout_noready", ready_cnt - r0, 0);
        check("timeout_vx_held", vx0, 5);
        run_vec("timeout_recover", vecs[1], 1'b0);

        // Single-cycle glitches on ps2_clk throughout every frame.
        run_vec("glitch", gvec, 1'b1);

        // Reset after byte 1 of a packet.
        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_vx", vx0, 0);
        check("midrst_dx", dx0, 0);
        check("midrst_right", right0, 0);
        check("midrst_vx_g2", vx2, 0);
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(20);
        run_vec("after_rst", vecs[4], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
